// File: rtl/aes_selftest_seq_if.sv
// Handshake and data bundle between the AES self-test sequencer and its environment.
// The environment drives start/mode/vectors/core results; the sequencer drives holds, status and display.
interface aes_selftest_seq_if;
    logic           start;
    logic [1:0]     mode;
    logic [0:127]   plain_text;
    logic [0:127]   expected_cipher;
    logic [0:127]   cipher_out;
    logic [0:127]   inv_out;
    logic           cipher_hold;
    logic           inv_hold;
    logic [0:127]   inv_in;
    logic           busy;
    logic           done;
    logic           pass;
    logic           enc_ok;
    logic           dec_ok;
    logic           err;
    logic [3:0]     disp_sel;
    logic [7:0]     disp_byte;

    modport master (
        output start, mode, plain_text, expected_cipher, cipher_out, inv_out, disp_sel,
        input  cipher_hold, inv_hold, inv_in, busy, done, pass, enc_ok, dec_ok, err, disp_byte
    );

    modport slave (
        input  start, mode, plain_text, expected_cipher, cipher_out, inv_out, disp_sel,
        output cipher_hold, inv_hold, inv_in, busy, done, pass, enc_ok, dec_ok, err, disp_byte
    );
endinterface

// File: rtl/aes_selftest_seq.sv
// BIST sequencer: runs Cipher/InvCipher cores for LAT cycles each, checks results against vectors.
// Latency start->done: LAT_ENC+LAT_DEC+3 (round trip), LAT+2 (single), 1 (reserved); start ignored while busy.
module aes_selftest_seq #(
    parameter int Nk      = 4,
    parameter int Nr      = Nk + 6,
    parameter int LAT_ENC = Nr + 1,
    parameter int LAT_DEC = Nr + 1,
    parameter int CW      = 5
) (
    input  logic              clk,
    input  logic              reset,
    aes_selftest_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ENC, ENC_CHK, DEC, DEC_CHK, DONE} state_t;

    localparam logic [CW-1:0] ENC_LAST = CW'(LAT_ENC - 1);
    localparam logic [CW-1:0] DEC_LAST = CW'(LAT_DEC - 1);

    state_t         state;
    logic [1:0]     mode_r;
    logic [CW-1:0]  phase;
    logic [0:127]   ct_reg;
    logic [0:127]   pt_reg;
    logic           last_dec;
    logic           cipher_hold, inv_hold, busy, done, pass, enc_ok, dec_ok, err;
    logic [0:127]   disp_src;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mode_r      <= 2'b00;
            phase       <= '0;
            ct_reg      <= '0;
            pt_reg      <= '0;
            last_dec    <= 1'b0;
            cipher_hold <= 1'b1;
            inv_hold    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            enc_ok      <= 1'b0;
            dec_ok      <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mode_r <= bus.mode;
                        pass   <= 1'b0;
                        enc_ok <= 1'b0;
                        dec_ok <= 1'b0;
                        busy   <= 1'b1;
                        phase  <= '0;
                        case (bus.mode)
                            2'b00, 2'b01: begin
                                state       <= ENC;
                                cipher_hold <= 1'b0;
                                err         <= 1'b0;
                            end
                            2'b10: begin
                                state    <= DEC;
                                inv_hold <= 1'b0;
                                err      <= 1'b0;
                            end
                            default: begin
                                state <= DONE;
                                err   <= 1'b1;
                            end
                        endcase
                    end
                end
                ENC: begin
                    if (phase == ENC_LAST) begin
                        phase       <= '0;
                        state       <= ENC_CHK;
                        cipher_hold <= 1'b1;
                    end else begin
                        phase <= phase + CW'(1);
                    end
                end
                ENC_CHK: begin
                    ct_reg   <= bus.cipher_out;
                    enc_ok   <= (bus.cipher_out == bus.expected_cipher);
                    last_dec <= 1'b0;
                    if (mode_r == 2'b00) begin
                        state    <= DEC;
                        inv_hold <= 1'b0;
                    end else begin
                        state <= DONE;
                    end
                end
                DEC: begin
                    if (phase == DEC_LAST) begin
                        phase    <= '0;
                        state    <= DEC_CHK;
                        inv_hold <= 1'b1;
                    end else begin
                        phase <= phase + CW'(1);
                    end
                end
                DEC_CHK: begin
                    pt_reg   <= bus.inv_out;
                    dec_ok   <= (bus.inv_out == bus.plain_text);
                    last_dec <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                    case (mode_r)
                        2'b00:   pass <= enc_ok & dec_ok;
                        2'b01:   pass <= enc_ok;
                        2'b10:   pass <= dec_ok;
                        default: pass <= 1'b0;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Round trip decrypts our own captured ciphertext, never the live core output.
    assign bus.inv_in = (mode_r == 2'b10) ? bus.expected_cipher : ct_reg;

    assign disp_src      = last_dec ? pt_reg : ct_reg;
    assign bus.disp_byte = disp_src[{bus.disp_sel, 3'b000} +: 8];

    assign bus.cipher_hold = cipher_hold;
    assign bus.inv_hold    = inv_hold;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.pass        = pass;
    assign bus.enc_ok      = enc_ok;
    assign bus.dec_ok      = dec_ok;
    assign bus.err         = err;
endmodule

// File: tb/tb_aes_selftest_seq.sv
// Bench for aes_selftest_seq: three instances (Nk=4,6,8) with latency-accurate behavioural core models.
module tb_aes_selftest_seq;
    localparam logic [0:127] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT4  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] CT6  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [0:127] CT8  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [0:127] JUNK = {4{32'hdeadbeef}};

    typedef struct {
        int           lat;
        logic         eok, dok, pass, err;
        logic [7:0]   d0, d15;
        int           encw, decw;
        logic [0:127] iref;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   start_v = '0;
    logic [1:0]   mode = 2'b00;
    logic [3:0]   disp_sel = 4'd0;
    logic [0:127] plain_text = PT;
    logic [0:127] exp_ct [3];
    logic [2:0]   ch_v, ih_v, busy_v, done_v, pass_v, eok_v, dok_v, err_v;
    logic [0:127] inv_in_v [3];
    logic [7:0]   disp_v [3];

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NK  = 4 + 2 * g;
        localparam int LAT = NK + 7;
        localparam logic [0:127] CTK = (g == 0) ? CT4 : ((g == 1) ? CT6 : CT8);

        aes_selftest_seq_if bus();
        int           ecnt = 0;
        int           dcnt = 0;
        logic [0:127] dprev = '0;

        assign bus.start           = start_v[g];
        assign bus.mode            = mode;
        assign bus.plain_text      = plain_text;
        assign bus.expected_cipher = exp_ct[g];
        assign bus.disp_sel        = disp_sel;
        // Core models: result only after LAT un-held cycles with a stable input, junk otherwise.
        assign bus.cipher_out = (ecnt >= LAT) ? CTK : JUNK;
        assign bus.inv_out    = (dcnt >= LAT && dprev == CTK) ? PT : JUNK;

        always @(posedge clk) begin
            ecnt  <= bus.cipher_hold ? 0 : ((ecnt < LAT) ? ecnt + 1 : ecnt);
            dcnt  <= bus.inv_hold ? 0 : ((bus.inv_in !== dprev) ? 1 : ((dcnt < LAT) ? dcnt + 1 : dcnt));
            dprev <= bus.inv_in;
        end

        assign ch_v[g]     = bus.cipher_hold;
        assign ih_v[g]     = bus.inv_hold;
        assign busy_v[g]   = bus.busy;
        assign done_v[g]   = bus.done;
        assign pass_v[g]   = bus.pass;
        assign eok_v[g]    = bus.enc_ok;
        assign dok_v[g]    = bus.dec_ok;
        assign err_v[g]    = bus.err;
        assign inv_in_v[g] = bus.inv_in;
        assign disp_v[g]   = bus.disp_byte;

        aes_selftest_seq #(.Nk(NK)) dut (.clk(clk), .reset(reset), .bus(bus));
    end

    function automatic exp_t mk(input int lat, input logic eok, input logic dok, input logic pass,
                                input logic err, input logic [7:0] d0, input logic [7:0] d15,
                                input int encw, input int decw, input logic [0:127] iref);
        exp_t e;
        e.lat = lat; e.eok = eok; e.dok = dok; e.pass = pass; e.err = err;
        e.d0 = d0; e.d15 = d15; e.encw = encw; e.decw = decw; e.iref = iref;
        return e;
    endfunction

    // Drive one run, push its expectation, then pop and compare once done is observed.
    task automatic run_case(input string name, input int k, input logic [1:0] m,
                            input logic [0:127] ec, input exp_t e, input bit poke);
        exp_t x;
        int   cyc, encw, decw, inbad, extra;
        sb.push_back(e);
        @(negedge clk);
        mode = m; exp_ct[k] = ec; start_v[k] = 1'b1;
        @(posedge clk);
        #1 start_v[k] = 1'b0;
        cyc = 0; encw = 0; decw = 0; inbad = 0;
        while (1) begin
            if (!ch_v[k]) encw++;
            if (!ih_v[k]) begin
                decw++;
                if (inv_in_v[k] !== e.iref) inbad++;
            end
            if (done_v[k] || cyc >= 200) break;
            @(posedge clk);
            cyc++;
            #1 start_v[k] = poke && (cyc == 3 || cyc == 8 || cyc == e.lat - 1);
        end
        x = sb.pop_front();
        checks++; if (cyc !== x.lat) begin failures++; $display("FAIL %s latency got=%0d want=%0d", name, cyc, x.lat); end
        checks++; if (busy_v[k] !== 1'b0) begin failures++; $display("FAIL %s busy_at_done got=%b want=0", name, busy_v[k]); end
        checks++; if (eok_v[k] !== x.eok) begin failures++; $display("FAIL %s enc_ok got=%b want=%b", name, eok_v[k], x.eok); end
        checks++; if (dok_v[k] !== x.dok) begin failures++; $display("FAIL %s dec_ok got=%b want=%b", name, dok_v[k], x.dok); end
        checks++; if (pass_v[k] !== x.pass) begin failures++; $display("FAIL %s pass got=%b want=%b", name, pass_v[k], x.pass); end
        checks++; if (err_v[k] !== x.err) begin failures++; $display("FAIL %s err got=%b want=%b", name, err_v[k], x.err); end
        checks++; if (encw !== x.encw) begin failures++; $display("FAIL %s cipher_hold_low got=%0d want=%0d", name, encw, x.encw); end
        checks++; if (decw !== x.decw) begin failures++; $display("FAIL %s inv_hold_low got=%0d want=%0d", name, decw, x.decw); end
        checks++; if (inbad !== 0) begin failures++; $display("FAIL %s inv_in_bad_cycles got=%0d want=0", name, inbad); end
        disp_sel = 4'd0; #1;
        checks++; if (disp_v[k] !== x.d0) begin failures++; $display("FAIL %s disp0 got=%h want=%h", name, disp_v[k], x.d0); end
        disp_sel = 4'd15; #1;
        checks++; if (disp_v[k] !== x.d15) begin failures++; $display("FAIL %s disp15 got=%h want=%h", name, disp_v[k], x.d15); end
        @(posedge clk); #1;
        checks++; if (done_v[k] !== 1'b0) begin failures++; $display("FAIL %s done_width got=%b want=0", name, done_v[k]); end
        extra = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done_v[k]) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL %s extra_done got=%0d want=0", name, extra); end
        checks++; if (pass_v[k] !== x.pass) begin failures++; $display("FAIL %s pass_retained got=%b want=%b", name, pass_v[k], x.pass); end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({ch_v[k], ih_v[k], busy_v[k], done_v[k], pass_v[k], eok_v[k], dok_v[k], err_v[k]} !== 8'b1100_0000) begin
                failures++;
                $display("FAIL reset_flags[%0d] got=%b want=11000000", k,
                         {ch_v[k], ih_v[k], busy_v[k], done_v[k], pass_v[k], eok_v[k], dok_v[k], err_v[k]});
            end
            checks++; if (disp_v[k] !== 8'h00) begin failures++; $display("FAIL reset_disp[%0d] got=%h want=00", k, disp_v[k]); end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_round_trip;
        run_case("rt_nk4", 0, 2'b00, CT4, mk(25, 1, 1, 1, 0, 8'h00, 8'hff, 11, 11, CT4), 1'b0);
    endtask

    task automatic test_enc_bad_vector;
        logic [0:127] bad;
        bad = CT4;
        bad[127] = ~bad[127];
        run_case("enc_bad", 0, 2'b01, bad, mk(13, 0, 0, 0, 0, 8'h69, 8'h5a, 11, 0, CT4), 1'b0);
    endtask

    task automatic test_dec_only;
        run_case("dec_only", 0, 2'b10, CT4, mk(13, 0, 1, 1, 0, 8'h00, 8'hff, 0, 11, CT4), 1'b0);
    endtask

    task automatic test_reserved;
        run_case("reserved", 0, 2'b11, CT4, mk(1, 0, 0, 0, 1, 8'h00, 8'hff, 0, 0, CT4), 1'b0);
    endtask

    task automatic test_param_sweep;
        run_case("rt_nk6", 1, 2'b00, CT6, mk(2 * (6 + 7) + 3, 1, 1, 1, 0, 8'h00, 8'hff, 13, 13, CT6), 1'b0);
        run_case("rt_nk8", 2, 2'b00, CT8, mk(2 * (8 + 7) + 3, 1, 1, 1, 0, 8'h00, 8'hff, 15, 15, CT8), 1'b0);
    endtask

    task automatic test_reset_mid_run;
        int extra;
        @(negedge clk);
        mode = 2'b00; exp_ct[0] = CT4; start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        checks++; if (ih_v[0] !== 1'b0) begin failures++; $display("FAIL midrst_in_dec inv_hold got=%b want=0", ih_v[0]); end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if ({ch_v[0], ih_v[0], busy_v[0], done_v[0], pass_v[0], eok_v[0]} !== 6'b110000) begin
            failures++;
            $display("FAIL midrst_state got=%b want=110000", {ch_v[0], ih_v[0], busy_v[0], done_v[0], pass_v[0], eok_v[0]});
        end
        extra = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done_v[0] || !ch_v[0] || !ih_v[0]) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL midrst_quiet got=%0d want=0", extra); end
    endtask

    task automatic test_back_to_back;
        run_case("busy_start", 0, 2'b01, CT4, mk(13, 1, 0, 1, 0, 8'h69, 8'h5a, 11, 0, CT4), 1'b1);
        run_case("rt_again", 0, 2'b00, CT4, mk(25, 1, 1, 1, 0, 8'h00, 8'hff, 11, 11, CT4), 1'b0);
    endtask

    initial begin
        exp_ct[0] = CT4; exp_ct[1] = CT6; exp_ct[2] = CT8;
        test_reset();
        test_round_trip();
        test_enc_bad_vector();
        test_dec_only();
        test_reserved();
        test_param_sweep();
        test_reset_mid_run();
        test_back_to_back();
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_selftest_seq.md
Name: aes_selftest_seq

Overview:
- Parametrised built-in self-test sequencer for the AES datapath. It drives the external Cipher and InvCipher cores through encrypt and/or decrypt phases sized by key length.
- It captures and compares each core result against supplied vectors, and reports pass/fail with a start/done handshake.
- It buffers the ciphertext so the inverse core is fed from a stable register rather than a live core output.
- It presents a selectable result byte for the BCD / seven-segment display path.

Parameters:
- Nk, 4, key length in 32-bit words; legal values 4, 6, 8.
- Nr, Nk+6, number of AES rounds.
- LAT_ENC, Nr+1, cycles the Cipher core needs out of hold before cipher_out is valid.
- LAT_DEC, Nr+1, cycles the InvCipher core needs out of hold before inv_out is valid.
- CW, 5, phase counter width; must satisfy 2^CW > max(LAT_ENC, LAT_DEC).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a test run; sampled only in IDLE.
- mode  in  2  test mode: 00 round-trip, 01 encrypt-only, 10 decrypt-only, 11 reserved.
- plain_text  in  128 [0:127]  reference plaintext.
- expected_cipher  in  128 [0:127]  reference ciphertext.
- cipher_out  in  128 [0:127]  Cipher core result.
- inv_out  in  128 [0:127]  InvCipher core result.
- cipher_hold  out  1  active-high hold/reset to the Cipher core.
- inv_hold  out  1  active-high hold/reset to the InvCipher core.
- inv_in  out  128 [0:127]  ciphertext fed to the InvCipher core.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  all applicable checks succeeded; valid from done, held until the next start.
- enc_ok, dec_ok, err  out  1 each  individual check results and reserved-mode flag.
- disp_sel  in  4  byte index for display; 0 selects bits [0:7], 15 selects bits [120:127].
- disp_byte  out  8  selected byte of the last result.

Behaviour:
- **Reset.** Reset forces state IDLE regardless of current state, including mid-run. On reset:
  - cipher_hold=1, inv_hold=1;
  - busy=0, done=0, pass=0, enc_ok=0, dec_ok=0, err=0;
  - ct_reg=0, pt_reg=0, phase counter=0, last_dec=0.
- **IDLE.**
  - Both holds stay at 1.
  - start=1 latches mode into mode_r and clears pass, enc_ok, dec_ok and err.
  - Next state:
    - mode 00 or 01: ENC;
    - mode 10: DEC;
    - mode 11: DONE with err=1.
  - start while busy=1 is ignored; there is no queueing.
- **ENC.**
  - cipher_hold=0, inv_hold=1.
  - The phase counter runs 0..LAT_ENC-1, then the state goes to ENC_CHK.
- **ENC_CHK** (1 cycle).
  - cipher_hold=1.
  - ct_reg <= cipher_out; enc_ok <= (cipher_out == expected_cipher); last_dec <= 0.
  - Next state: DEC for mode 00, DONE for mode 01.
- **DEC.**
  - inv_hold=0, cipher_hold=1.
  - inv_in = ct_reg in mode 00, expected_cipher in mode 10; it is constant for the whole phase.
  - The phase counter runs 0..LAT_DEC-1, then the state goes to DEC_CHK.
- **DEC_CHK** (1 cycle).
  - inv_hold=1.
  - pt_reg <= inv_out; dec_ok <= (inv_out == plain_text); last_dec <= 1.
  - Next state: DONE.
- **DONE** (1 cycle).
  - done=1, busy=0 from the next cycle, state goes to IDLE.
  - pass:
    - mode 00: enc_ok & dec_ok;
    - mode 01: enc_ok;
    - mode 10: dec_ok;
    - mode 11: 0.
- **Latency.** Latency counts from the start-sampling edge to the done-high cycle:
  - mode 00: LAT_ENC + LAT_DEC + 3 (25 for Nk=4);
  - mode 01 or 10: LAT + 2;
  - mode 11: 1.
- **Display.**
  - disp_byte comes from pt_reg when last_dec=1, otherwise from ct_reg.
  - It is combinational on disp_sel and the registers, valid in all states.
- **Result retention.** Results are not cleared by done; only start or reset clears them.

Test Plan:
- **Nk=4 round-trip.** Inputs: mode=00, plain_text=00112233445566778899aabbccddeeff, expected_cipher=69c4e0d86a7b0430d8cdb78070b4c55a, correct core models. Required: done pulses exactly 25 cycles after start; enc_ok=dec_ok=pass=1; disp_sel=15 gives disp_byte=8'hff.
- **Encrypt-only with a wrong expected vector.** Inputs: mode=01, expected_cipher bit 127 flipped. Required: done at cycle 13; enc_ok=0, pass=0; inv_hold stays 1 throughout; disp_sel=15 gives 8'h5a.
- **Decrypt-only.** Inputs: mode=10. Required: inv_in equals expected_cipher for all 11 DEC cycles; dec_ok=1, pass=1, done at cycle 13.
- **Parameter sweep.** Run Nk=6 and Nk=8 in round-trip mode. Required: done at 2*(Nk+7)+3 cycles (29 and 33); hold low-windows last exactly 13 and 15 cycles.
- **Reset mid-run and start while busy.** Assert reset during DEC. Required next cycle: IDLE, both holds 1, pass=0, busy=0. Also: start pulses while busy cause no restart and no extra done.
- **Reserved mode.** Inputs: mode=11. Required: done one cycle after start; err=1, pass=0; neither hold deasserts.
